// File: rtl/timer_counter.sv
// timer_counter: memory-mapped countdown timer, sole interrupt source for CP0 HWInt.
//
// Registers (word select addr = bus addr[3:2]):
//   0 CTRL     [0] EN, [2:1] MODE (1 = auto-reload, else one-shot), [3] IM
//   1 PRESET   reload value, full word
//   2 COUNT    current count, read-only
//   3 PRESCALE divider compare value (only with TC_PRESCALE_EN, else reads 0)
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   addr   register select
//   we     write strobe
//   wdata  write data
//   rdata  combinational read data of the selected register
//   irq    registered interrupt request (irq_flag & IM)
//
// Optional feature macro: TC_PRESCALE_EN (adds PRESCALE register and count divider).
module timer_counter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       addr,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             irq
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CNT  = 2'd2;
  localparam logic [1:0] S_INT  = 2'd3;

  localparam logic [1:0] A_CTRL     = 2'd0;
  localparam logic [1:0] A_PRESET   = 2'd1;
  localparam logic [1:0] A_COUNT    = 2'd2;
  localparam logic [1:0] A_PRESCALE = 2'd3;

  localparam logic [1:0] MODE_RELOAD = 2'd1;

  logic             r_en;
  logic [1:0]       r_mode;
  logic             r_im;
  logic [WIDTH-1:0] r_preset;
  logic [WIDTH-1:0] r_count;
  logic [1:0]       r_state;
  logic             r_irq_flag;
  logic             r_irq;

  logic             w_en_nxt;
  logic [1:0]       w_mode_nxt;
  logic             w_im_nxt;
  logic [WIDTH-1:0] w_preset_nxt;
  logic [WIDTH-1:0] w_count_nxt;
  logic [1:0]       w_state_nxt;
  logic             w_flag_nxt;

  logic             w_ctrl_wr;
  logic             w_preset_wr;
  logic             w_tick;

  assign w_ctrl_wr   = we && (addr == A_CTRL);
  assign w_preset_wr = we && (addr == A_PRESET);

`ifdef TC_PRESCALE_EN
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_div;
  logic [PRESCALE_W-1:0] w_prescale_nxt;
  logic [PRESCALE_W-1:0] w_div_nxt;
  logic                  w_prescale_wr;

  assign w_prescale_wr = we && (addr == A_PRESCALE);
  // COUNT only advances on the cycle the divider reaches PRESCALE
  assign w_tick        = (r_div == r_prescale);

  // Divider next-state: runs in CNT, cleared in IDLE/LOAD and on PRESCALE write
  always_comb begin
    w_prescale_nxt = r_prescale;
    w_div_nxt      = r_div;
    if (r_state == S_CNT) begin
      w_div_nxt = w_tick ? '0 : r_div + PRESCALE_W'(1);
    end else if (r_state != S_INT) begin
      w_div_nxt = '0;
    end
    if (w_prescale_wr) begin
      w_prescale_nxt = wdata[PRESCALE_W-1:0];
      w_div_nxt      = '0;
    end
  end

  // Divider registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prescale <= '0;
      r_div      <= '0;
    end else begin
      r_prescale <= w_prescale_nxt;
      r_div      <= w_div_nxt;
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  // Timer FSM next-state; software writes applied last so they win over the FSM
  always_comb begin
    w_en_nxt     = r_en;
    w_mode_nxt   = r_mode;
    w_im_nxt     = r_im;
    w_preset_nxt = r_preset;
    w_count_nxt  = r_count;
    w_state_nxt  = r_state;
    w_flag_nxt   = r_irq_flag;

    case (r_state)
      S_IDLE: begin
        if (r_en) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = S_CNT;
      end
      S_CNT: begin
        if (!r_en) begin
          w_state_nxt = S_IDLE;
        end else if (w_tick) begin
          if (r_count > WIDTH'(1)) begin
            w_count_nxt = r_count - WIDTH'(1);
          end else begin
            // Terminal count: saturate at zero, never wrap
            w_count_nxt = '0;
            w_flag_nxt  = 1'b1;
            w_state_nxt = S_INT;
          end
        end
      end
      S_INT: begin
        if (r_mode == MODE_RELOAD) begin
          w_flag_nxt  = 1'b0;
          w_state_nxt = S_LOAD;
        end else begin
          w_en_nxt    = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_ctrl_wr) begin
      w_en_nxt   = wdata[0];
      w_mode_nxt = wdata[2:1];
      w_im_nxt   = wdata[3];
      w_flag_nxt = 1'b0;
      // Disabling during CNT freezes COUNT and cancels a coincident terminal count
      if (!wdata[0] && (r_state == S_CNT)) begin
        w_state_nxt = S_IDLE;
        w_count_nxt = r_count;
      end
    end

    if (w_preset_wr) begin
      w_preset_nxt = wdata;
      w_flag_nxt   = 1'b0;
    end
  end

  // State registers; irq registered from the next flag/mask values
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en       <= 1'b0;
      r_mode     <= 2'd0;
      r_im       <= 1'b0;
      r_preset   <= '0;
      r_count    <= '0;
      r_state    <= S_IDLE;
      r_irq_flag <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_en       <= w_en_nxt;
      r_mode     <= w_mode_nxt;
      r_im       <= w_im_nxt;
      r_preset   <= w_preset_nxt;
      r_count    <= w_count_nxt;
      r_state    <= w_state_nxt;
      r_irq_flag <= w_flag_nxt;
      r_irq      <= w_flag_nxt & w_im_nxt;
    end
  end

  assign irq = r_irq;

  // Read mux
  always_comb begin
    rdata = '0;
    case (addr)
      A_CTRL:   rdata = {{(WIDTH-4){1'b0}}, r_im, r_mode, r_en};
      A_PRESET: rdata = r_preset;
      A_COUNT:  rdata = r_count;
`ifdef TC_PRESCALE_EN
      A_PRESCALE: rdata = WIDTH'(r_prescale);
`else
      A_PRESCALE: rdata = WIDTH'({PRESCALE_W{1'b0}});
`endif
      default:  rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed and randomized checks of timer_counter against a
// behavioural model of the register/interrupt rules.
module tb_timer_counter;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   addr;
  logic         we;
  logic [W-1:0] wdata;
  logic [W-1:0] rdata;
  logic         irq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  timer_counter #(.WIDTH(W), .PRESCALE_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  // ---------------- behavioural model ----------------
  typedef enum int {PH_IDLE, PH_LOAD, PH_CNT, PH_INT} phase_t;

  bit           m_en     = 1'b0;
  logic [1:0]   m_mode   = 2'd0;
  bit           m_im     = 1'b0;
  bit           m_flag   = 1'b0;
  logic [W-1:0] m_preset = '0;
  logic [W-1:0] m_count  = '0;
  phase_t       m_phase  = PH_IDLE;
  logic [7:0]   m_pscale = 8'd0;
  int           m_div    = 0;

  task automatic model_clear();
    m_en = 1'b0; m_mode = 2'd0; m_im = 1'b0; m_flag = 1'b0;
    m_preset = '0; m_count = '0; m_phase = PH_IDLE;
    m_pscale = 8'd0; m_div = 0;
  endtask

  task automatic model_edge();
    bit           ctrl_wr = we && (addr == 2'd0);
    bit           pre_wr  = we && (addr == 2'd1);
    bit           ps_wr   = we && (addr == 2'd3);
    bit           adv;
    phase_t       ph   = m_phase;
    logic [W-1:0] cnt  = m_count;
    bit           flag = m_flag;
    bit           en   = m_en;
`ifdef TC_PRESCALE_EN
    adv = (m_div == int'(m_pscale));
`else
    adv = 1'b1;
`endif
    if (m_phase == PH_CNT && ctrl_wr && !wdata[0]) begin
      ph = PH_IDLE;
    end else begin
      case (m_phase)
        PH_IDLE: if (m_en) ph = PH_LOAD;
        PH_LOAD: begin cnt = m_preset; ph = PH_CNT; end
        PH_CNT: begin
          if (!m_en) ph = PH_IDLE;
          else if (adv) begin
            if (m_count > 1) cnt = m_count - 1;
            else begin cnt = '0; flag = 1'b1; ph = PH_INT; end
          end
        end
        default: begin
          if (m_mode == 2'd1) begin ph = PH_LOAD; flag = 1'b0; end
          else begin en = 1'b0; ph = PH_IDLE; end
        end
      endcase
    end
    if (m_phase == PH_CNT && m_en) m_div = adv ? 0 : m_div + 1;
    else m_div = 0;
    if (ps_wr) begin
`ifdef TC_PRESCALE_EN
      m_pscale = wdata[7:0];
`endif
      m_div = 0;
    end
    if (ctrl_wr) begin
      en = wdata[0]; m_mode = wdata[2:1]; m_im = wdata[3]; flag = 1'b0;
    end
    if (pre_wr) begin
      m_preset = wdata; flag = 1'b0;
    end
    m_phase = ph; m_count = cnt; m_flag = flag; m_en = en;
  endtask

  function automatic logic [W-1:0] model_rdata(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return W'(m_pscale);
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) model_clear();
    else        model_edge();
  end

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model
  always @(posedge clk) begin
    #2;
    check("model_rdata", rdata, model_rdata(addr));
    check("model_irq", W'(irq), W'(m_flag & m_im));
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  int pulses;

  initial begin
    reset = 1'b1; we = 1'b0; addr = 2'd0; wdata = '0;
    #1 reset = 1'b0;
    #1;
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      check("reset_rdata", rdata, '0);
    end
    check("reset_irq", W'(irq), '0);
    @(negedge clk) reset = 1'b1;

    // One-shot, PRESET=4
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h9);
    addr = 2'd2;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k >= 2 && k <= 6) check("oneshot_count", rdata, W'(6 - k));
      if (k == 5) check("oneshot_irq_early", W'(irq), '0);
      if (k == 6) check("oneshot_irq", W'(irq), 32'd1);
    end
    @(negedge clk) addr = 2'd0;
    step();
    check("oneshot_en_clr", rdata, 32'h8);
    check("oneshot_irq_hold", W'(irq), 32'd1);
    wr(2'd0, 32'h8);
    check("oneshot_irq_ack", W'(irq), '0);

    // Auto-reload, PRESET=3: one-cycle pulse every 5 cycles
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    addr = 2'd2;
    pulses = 0;
    for (int k = 1; k <= 15; k++) begin
      step();
      pulses += int'(irq);
      if (k == 7 || k == 12) check("reload_count", rdata, 32'd3);
      if (k == 10) check("reload_irq", W'(irq), 32'd1);
      if (k == 11) check("reload_pulse_end", W'(irq), '0);
    end
    check("reload_pulses", W'(pulses), 32'd3);
    wr(2'd0, 32'h0);
    repeat (3) step();

    // IM=0 masks; later CTRL write clears the pending flag
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    addr = 2'd2;
    for (int k = 1; k <= 14; k++) begin
      step();
      check("masked_irq", W'(irq), '0);
      if (k == 12) check("masked_count", rdata, '0);
    end
    wr(2'd0, 32'h8);
    check("masked_after_im", W'(irq), '0);
    step();
    check("masked_after_im2", W'(irq), '0);

    // Disable on the terminal-count cycle: write wins
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    addr = 2'd2;
    repeat (3) step();
    check("cancel_pre", rdata, 32'd1);
    wr(2'd0, 32'h8);
    check("cancel_ctrl", rdata, 32'h8);
    addr = 2'd2;
    for (int k = 0; k < 4; k++) begin
      step();
      check("cancel_count", rdata, 32'd1);
      check("cancel_irq", W'(irq), '0);
    end

`ifdef TC_PRESCALE_EN
    // Divide by 3, PRESET=2: irq after edge 8
    wr(2'd3, 32'd2);
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    addr = 2'd2;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 4) check("ps_count_hold", rdata, 32'd2);
      if (k == 5) check("ps_count_dec", rdata, 32'd1);
      if (k == 7) check("ps_irq_early", W'(irq), '0);
      if (k == 8) check("ps_irq", W'(irq), 32'd1);
    end
    wr(2'd3, 32'd0);
    wr(2'd0, 32'h0);
`else
    // PRESCALE absent: addr 3 ignores writes and reads zero
    wr(2'd3, 32'hFF);
    addr = 2'd3;
    step();
    check("no_prescale", rdata, '0);
`endif

    // Reset asserted mid-count
    wr(2'd1, 32'd9);
    wr(2'd0, 32'h9);
    addr = 2'd2;
    repeat (6) step();
    check("midrst_pre", rdata, 32'd5);
    #1 reset = 1'b0;
    #1;
    check("midrst_count", rdata, '0);
    check("midrst_irq", W'(irq), '0);
    @(negedge clk) reset = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      addr = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        we = 1'b1;
        case (addr)
          2'd0:    wdata = W'($urandom_range(0, 15) | 32'(($urandom_range(0, 3) != 0)));
          2'd1:    wdata = W'($urandom_range(0, 6));
          2'd2:    wdata = $urandom;
          default: wdata = $urandom & 32'hFFFF_FF03;
        endcase
      end else begin
        we = 1'b0;
      end
    end
    @(negedge clk) we = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
